// File: rtl/spi_reg_master_if.sv
// spi_reg_master_if: request/response handshake and SPI pins of spi_reg_master.
interface spi_reg_master_if #(parameter int WIDTH = 8) ();
  logic             start;
  logic [7:0]       cmd;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic             SCK;
  logic             CS;
  logic             SI;
  logic             SO;
  modport master (input start, cmd, wdata, SO, output busy, done, rdata, SCK, CS, SI);
  modport slave  (output start, cmd, wdata, SO, input busy, done, rdata, SCK, CS, SI);
endinterface

// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI register master shifting a cmd byte then WIDTH data bits, MSB first.
// Define SPI_REG_MASTER_READBACK_EN to capture SO into rdata on read transfers (cmd[5]=1).
module spi_reg_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input logic              FX2_CLK,
  input logic              reset,
  spi_reg_master_if.master bus
);
  localparam int N  = 8 + WIDTH;
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          ph_q, ph_d;
  logic [N-1:0]  sr_q, sr_d;
  logic          hp_end, fall, done, busy, accept, cs;
  assign hp_end = cnt_q == CW'(CLK_DIV - 1);
  assign fall   = state_q == SHIFT && !ph_q && hp_end;
  assign done   = state_q == GAP && hp_end;
  assign busy   = state_q != IDLE && !done;
  assign accept = bus.start && !busy;
  assign cs     = state_q inside {SETUP, SHIFT, HOLD};
  assign bus.done = done;
  assign bus.busy = busy;
  assign bus.CS   = cs;
  assign bus.SCK  = state_q == SHIFT && !ph_q;
  assign bus.SI   = cs && sr_q[N-1];
  // ph_q=0 is the SCK-high half of a period, ph_q=1 the low half; SI advances on the fall
  always_comb begin
    state_d = state_q;
    cnt_d   = state_q == IDLE || hp_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    ph_d    = ph_q;
    sr_d    = sr_q;
    if (accept) begin
      state_d = SETUP;
      sr_d    = {bus.cmd, bus.wdata};
      cnt_d   = '0;
    end else if (hp_end) begin
      case (state_q)
        SETUP: begin
          state_d = SHIFT;
          ph_d    = 1'b0;
          bit_d   = '0;
        end
        SHIFT: begin
          ph_d  = !ph_q;
          sr_d  = ph_q ? sr_q : sr_q << 1;
          bit_d = ph_q ? bit_q + 1'b1 : bit_q;
          state_d = ph_q && bit_q == BW'(N - 1) ? HOLD : SHIFT;
        end
        HOLD:    state_d = GAP;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge FX2_CLK or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ph_q    <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      sr_q    <= sr_d;
    end
`ifdef SPI_REG_MASTER_READBACK_EN
  logic             rd_q, rd_d;
  logic [WIDTH-1:0] cap_q, cap_d, rdata_q, rdata_d;
  // SO carries the response during the data field, i.e. falls 9..8+WIDTH
  always_comb begin
    rd_d    = accept ? bus.cmd[5] : rd_q;
    cap_d   = fall && rd_q && bit_q >= BW'(8) ? {cap_q[WIDTH-2:0], bus.SO} : cap_q;
    rdata_d = done && rd_q ? cap_q : rdata_q;
  end
  always_ff @(posedge FX2_CLK or posedge reset)
    if (reset) begin
      rd_q    <= 1'b0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      rd_q    <= rd_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  assign bus.rdata = rdata_q;
`else
  assign bus.rdata = '0;
`endif
endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: table-driven and random frames against a frame-level model of spi_reg_master.
module tb_spi_reg_master;
  localparam int W = 8, H = 4, N = 8 + W;
`ifdef SPI_REG_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  spi_reg_master_if #(.WIDTH(W)) bus ();
  spi_reg_master_if #(.WIDTH(W)) bus1 ();
  spi_reg_master #(.WIDTH(W), .CLK_DIV(H)) dut  (.FX2_CLK(clk), .reset(rst), .bus(bus));
  spi_reg_master #(.WIDTH(W), .CLK_DIV(1)) dut1 (.FX2_CLK(clk), .reset(rst), .bus(bus1));
  int errs = 0, checks = 0;
  logic [W-1:0] model_rdata = '0;
  typedef struct packed {
    logic [7:0]   c;
    logic [W-1:0] wd;
    logic [W-1:0] so;
    logic         poke;
    logic [N-1:0] si;
  } vec_t;
  vec_t tbl [5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic frame(input logic [7:0] c, input logic [W-1:0] wd, input logic [W-1:0] so,
                       input bit poke, input logic [N-1:0] exp_si, input string tag);
    logic [N-1:0] si_seq;
    int rises, cs_hi, cs_lo, dones, cyc, extra;
    logic sck_prev;
    bit ended;
    si_seq = '0; rises = 0; cs_hi = 0; cs_lo = 0; dones = 0; cyc = 0; extra = 0;
    sck_prev = 1'b0; ended = 1'b0;
    bus.cmd = c; bus.wdata = wd; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cmd = ~c; bus.wdata = ~wd;
    chk({tag, "_busy"}, bus.busy, 1);
    while (!ended && cyc < 400) begin
      cyc++;
      if (bus.SCK && !sck_prev) begin
        rises++;
        if (rises <= N) si_seq[N-rises] = bus.SI;
        bus.SO = (rises >= 9 && rises <= N) ? so[W-1-(rises-9)] : 1'($urandom);
      end
      sck_prev = bus.SCK;
      if (bus.CS) cs_hi++; else cs_lo++;
      if (bus.done) begin dones++; ended = 1'b1; end
      bus.start = poke && rises == 3;
      if (!ended) @(negedge clk);
    end
    bus.start = 1'b0;
    if (RB && c[5]) model_rdata = so;
    chk({tag, "_si"}, 32'(si_seq), 32'(exp_si));
    chk({tag, "_rises"}, rises, N);
    chk({tag, "_cs_hi"}, cs_hi, (2 * N + 2) * H);
    chk({tag, "_cs_lo_to_done"}, cs_lo, H);
    chk({tag, "_dones"}, dones, 1);
    @(negedge clk);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'(model_rdata));
    repeat (2 * H) begin
      if (bus.CS || bus.done || bus.busy) extra++;
      @(negedge clk);
    end
    chk({tag, "_idle_after"}, extra, 0);
  endtask
  initial begin
    int r, cyc, d1, r1, lo, hi, rd;
    logic prev, p1;
    bit seen_hi;
    logic [7:0] c;
    logic [W-1:0] wd, so;
    tbl[0] = '{8'h05, 8'hA5, 8'h00, 1'b0, 16'h05A5};
    tbl[1] = '{8'h23, 8'h00, 8'h3C, 1'b0, 16'h2300};
    tbl[2] = '{8'h05, 8'h11, 8'hFF, 1'b1, 16'h0511};
    tbl[3] = '{8'hFF, 8'hFF, 8'hC3, 1'b0, 16'hFFFF};
    tbl[4] = '{8'h20, 8'h01, 8'h81, 1'b0, 16'h2001};
    bus.start = 1'b0; bus.cmd = '0; bus.wdata = '0; bus.SO = 1'b0;
    bus1.start = 1'b0; bus1.cmd = '0; bus1.wdata = '0; bus1.SO = 1'b0;
    #2;
    chk("rst_sck", bus.SCK, 0);
    chk("rst_cs", bus.CS, 0);
    chk("rst_si", bus.SI, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      frame(tbl[i].c, tbl[i].wd, tbl[i].so, tbl[i].poke, tbl[i].si, $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) begin
      c = 8'($urandom); wd = W'($urandom); so = W'($urandom);
      frame(c, wd, so, 1'b0, {c, wd}, $sformatf("rnd%0d", i));
    end
    // reset at SCK rise 5 aborts the frame with no done
    bus.cmd = 8'h0F; bus.wdata = 8'h00; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    r = 0; cyc = 0; prev = 1'b0; rd = 0;
    while (r < 5 && cyc < 300) begin
      @(posedge clk); #1;
      if (bus.SCK && !prev) r++;
      prev = bus.SCK;
      if (bus.done) rd++;
      cyc++;
    end
    chk("abort_reached_rise5", r, 5);
    chk("abort_pre_si", bus.SI, 1);
    rst = 1'b1;
    #1;
    chk("abort_sck", bus.SCK, 0);
    chk("abort_cs", bus.CS, 0);
    chk("abort_si", bus.SI, 0);
    chk("abort_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;
    repeat (3 * H) begin
      @(negedge clk);
      if (bus.done || bus.CS) rd++;
    end
    chk("abort_no_done", rd, 0);
    frame(8'h05, 8'hA5, 8'h00, 1'b0, 16'h05A5, "post_abort");
    // CLK_DIV=1 with start held: back-to-back frames, 1-cycle CS-low gap
    bus1.cmd = 8'h3A; bus1.wdata = 8'h5C; bus1.start = 1'b1;
    d1 = 0; r1 = 0; lo = 0; hi = 0; cyc = 0; p1 = 1'b0; seen_hi = 1'b0;
    while (d1 < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (bus1.SCK && !p1) r1++;
      p1 = bus1.SCK;
      if (bus1.CS) begin
        if (seen_hi && lo > 0) chk("b2b_gap", lo, 1);
        hi++; lo = 0; seen_hi = 1'b1;
      end else begin
        if (hi > 0) chk("b2b_cs_hi", hi, 2 * N + 2);
        hi = 0;
        if (seen_hi) lo++;
      end
      if (bus1.done) begin
        d1++;
        chk("b2b_done_cs", bus1.CS, 0);
      end
    end
    bus1.start = 1'b0;
    chk("b2b_frames", d1, 3);
    chk("b2b_rises", r1, 3 * N);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/spi_reg_master.md
SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data field width in bits (>=2).
REQ-002 SHALL have parameter CLK_DIV, default 4, FX2_CLK cycles per SCK half-period (>=1).
REQ-003 SHALL have port FX2_CLK  input  1  master clock; one clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  transfer request, sampled when busy=0.
REQ-006 SHALL have port cmd  input  8  command byte, MSB first; cmd[5]=1 marks a read.
REQ-007 SHALL have port wdata  input  WIDTH  write data, MSB first.
REQ-008 SHALL have port busy  output  1  transfer in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  WIDTH  data captured from SO.
REQ-011 SHALL have port SCK  output  1  serial clock, idle low.
REQ-012 SHALL have port CS  output  1  chip select, active high.
REQ-013 SHALL have port SI  output  1  serial data to the slave.
REQ-014 SHALL have port SO  input  1  serial data from the slave.

Function
REQ-015 SHALL latch cmd, wdata and the read flag (cmd[5]) on the cycle start=1 and busy=0, and assert busy the next cycle.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL use states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE, each half-period lasting CLK_DIV cycles.
REQ-018 SETUP: CS=1, SCK=0, SI=cmd[7]; lasts one half-period.
REQ-019 SHIFT: 8+WIDTH SCK periods, each one half-period high then one half-period low; slave samples SI on SCK rise.
REQ-020 SI SHALL update on each SCK fall to the next bit: cmd[7..0], then wdata[WIDTH-1..0].
REQ-021 For a read transfer, SO SHALL be sampled on SCK falling edges 9 through 8+WIDTH and shifted into a capture register MSB first.
REQ-022 HOLD: CS=1, SCK=0 for one half-period after the last SCK fall; CS=1 lasts exactly (2*(8+WIDTH)+2)*CLK_DIV cycles in total.
REQ-023 GAP: CS=0, SCK=0 for one half-period so the slave's CS-falling strobe is generated; done=1 and busy=0 on the last GAP cycle.
REQ-024 rdata SHALL update only on done of a read transfer; write transfers SHALL leave rdata unchanged.
REQ-025 A start asserted in the done cycle SHALL be accepted (busy=0 in that cycle).
REQ-026 The SCK divider counter SHALL wrap from CLK_DIV-1 to 0; CLK_DIV=1 SHALL give SCK = FX2_CLK/2.

Reset
REQ-027 On reset=1, SHALL immediately force SCK=0, CS=0, SI=0, busy=0, done=0, rdata=0, state IDLE, counters 0.
REQ-028 Reset mid-transfer SHALL abort with no done pulse; the first start after release SHALL begin a full new transfer.

Configuration
REQ-029 Macro SPI_REG_MASTER_READBACK_EN defined: REQ-021 and REQ-024 apply.
REQ-030 Macro SPI_REG_MASTER_READBACK_EN undefined: no capture logic; rdata tied to 0; SO ignored; all other timing identical.

Verification
REQ-031 WIDTH=8, CLK_DIV=4, cmd=0x05, wdata=0xA5 -> SI sequence 0000_0101_1010_0101; CS high 136 cycles; done 4 cycles after CS falls; rdata unchanged.
REQ-032 cmd=0x23 with slave model driving 0x3C on SO after rising edge 9 -> rdata=0x3C at done.
REQ-033 start pulsed during SHIFT -> ignored; exactly 16 SCK rises; one done.
REQ-034 reset asserted at SCK rise 5 -> CS, SCK, SI low the same cycle; no done; next start yields a full 16-bit frame.
REQ-035 CLK_DIV=1, start held high continuously -> back-to-back frames, each with a CS-low gap of 1 cycle and one done per frame.
REQ-036 Macro undefined, read of 0x3C -> rdata stays 0x00; SI/SCK/CS timing matches REQ-031.
